// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: the operand width,
// the funct3 op encodings, the FSM state encoding, and the operand signedness helpers.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational two's-complement conditional negation of two values.
// It is used on the operands (signed value to magnitude) and on the result
// (magnitude back to signed product/quotient and remainder).
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int YW = XLEN
) (
  input  logic [XW-1:0] x,
  input  logic          neg_x,
  input  logic [YW-1:0] y,
  input  logic          neg_y,
  output logic [XW-1:0] x_fix,
  output logic [YW-1:0] y_fix
);

  // Negate each value when its flag is set. Wrapping is modulo 2^width, so a
  // 0x80000000 input becomes the unsigned magnitude 2^31.
  always_comb begin
    x_fix = neg_x ? (~x + {{(XW-1){1'b0}}, 1'b1}) : x;
    y_fix = neg_y ? (~y + {{(YW-1){1'b0}}, 1'b1}) : y;
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit. It has a fixed latency: the request is
// accepted on edge 0, one iteration runs on each of edges 1..32, and the result
// is valid (done) for the single cycle that follows edge 32.
// Multiply uses radix-2 shift-add on magnitudes. Divide uses restoring
// division on magnitudes. Both share one 33-bit adder/subtractor.
//
// state  | meaning
// S_IDLE | waiting for start
// S_MUL  | shift-add iterations
// S_DIV  | restoring-division iterations
// S_DONE | result valid, done=1; start here is accepted back-to-back
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import muldiv_pkg::*;

  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

  state_e            state_q, state_d;
  logic              accept;
  logic              last_iter;

  logic [2:0]        op_q;
  logic [4:0]        tag_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   bmag_q;
  logic              neg_a_q, neg_b_q;
  logic              div_zero_q, div_ovf_q;
  logic [5:0]        count_q;
  // Multiply: {product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] work_q;

  logic [XLEN-1:0]   amag, bmag;
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     add_x, add_y;
  logic              add_sub;
  logic [XLEN+1:0]   add_res;
  logic              div_ge;
  logic [2*XLEN-1:0] work_step;
  logic [2*XLEN-1:0] fix_x, fix_x_out;
  logic [XLEN-1:0]   fix_y_out;
  logic [XLEN-1:0]   final_result;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (count_q == LAST_ITER);

  // The incoming operands are converted to magnitudes before they are latched.
  muldiv_sign_fix #(.XW(XLEN), .YW(XLEN)) u_operand_fix (
    .x     (a),
    .neg_x (op_a_signed(op) && a[XLEN-1]),
    .y     (b),
    .neg_y (op_b_signed(op) && b[XLEN-1]),
    .x_fix (amag),
    .y_fix (bmag)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = op[2] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = op[2] ? S_DIV : S_MUL;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi = work_q[2*XLEN-1:XLEN];
  assign lo = work_q[XLEN-1:0];

  // Operand select for the shared adder: add in the multiplicand or trial-subtract the divisor
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (op_q[2]) begin
      add_x   = {hi, lo[XLEN-1]};
      add_y   = {1'b0, bmag_q};
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, hi};
      add_y   = lo[0] ? {1'b0, bmag_q} : '0;
    end
  end

  assign add_res = {1'b0, add_x} + {1'b0, add_y ^ {(XLEN+1){add_sub}}}
                 + {{(XLEN+1){1'b0}}, add_sub};
  // The carry out of the subtraction means there was no borrow (shifted remainder >= divisor)
  assign div_ge  = add_res[XLEN+1];

  // One iteration of the work register
  always_comb begin
    if (op_q[2])
      work_step = {(div_ge ? add_res[XLEN-1:0] : add_x[XLEN-1:0]), lo[XLEN-2:0], div_ge};
    else
      work_step = {add_res[XLEN:0], lo[XLEN-1:1]};
  end

  assign fix_x = op_q[2] ? {{XLEN{1'b0}}, work_step[XLEN-1:0]} : work_step;

  // Product and quotient share the a^b sign. The remainder follows the sign of a.
  muldiv_sign_fix #(.XW(2*XLEN), .YW(XLEN)) u_result_fix (
    .x     (fix_x),
    .neg_x (neg_a_q ^ neg_b_q),
    .y     (work_step[2*XLEN-1:XLEN]),
    .neg_y (neg_a_q),
    .x_fix (fix_x_out),
    .y_fix (fix_y_out)
  );

  // Result half-select and the RISC-V divide special cases
  always_comb begin
    final_result = '0;
    case (op_q)
      OP_MUL:                      final_result = fix_x_out[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = fix_x_out[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)     final_result = '1;
        else if (div_ovf_q) final_result = {1'b1, {(XLEN-1){1'b0}}};
        else                final_result = fix_x_out[XLEN-1:0];
      end
      default: begin
        if (div_zero_q)     final_result = a_q;
        else if (div_ovf_q) final_result = '0;
        else                final_result = fix_y_out;
      end
    endcase
  end

  // Operand capture on accept, iteration while busy, result capture on the last iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      tag_q      <= '0;
      a_q        <= '0;
      bmag_q     <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      count_q    <= '0;
      work_q     <= '0;
      result     <= '0;
      rd_out     <= '0;
    end else if (accept) begin
      op_q       <= op;
      tag_q      <= rd_in;
      a_q        <= a;
      bmag_q     <= bmag;
      neg_a_q    <= op_a_signed(op) && a[XLEN-1];
      neg_b_q    <= op_b_signed(op) && b[XLEN-1];
      div_zero_q <= (b == '0);
      div_ovf_q  <= op_b_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      count_q    <= '0;
      work_q     <= {{XLEN{1'b0}}, amag};
    end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
      work_q  <= work_step;
      count_q <= count_q + 6'd1;
      if (last_iter) begin
        result <= final_result;
        rd_out <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against
// an arithmetic reference model, and hand-written timing/reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model written directly from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    longint p;
    longint unsigned pu;
    logic ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin pu = {32'd0, x} * {32'd0, y}; return pu[31:0]; end
      3'd1: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      3'd2: begin p = longint'(sx) * longint'({32'd0, y}); return p[63:32]; end
      3'd3: begin pu = {32'd0, x} * {32'd0, y}; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf)    return 32'd0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Called at posedge+1; issues one request, checks latency, result, tag and the done pulse width
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] exp, input string name);
    int n;
    op = f; a = x; b = y; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~x; b = ~y; rd_in = ~r;
    check({name, " busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, 32'd32);
    check({name, " result"}, result, exp);
    check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, r});
    @(posedge clk); #1;
    check({name, " done width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0]  f;
    logic [31:0] x, y;
    logic [4:0]  r;

    vecs[0]  = '{3'd0, 32'd6,          32'd7,          5'd3,  32'd42};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd4,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd7,          32'd0,          5'd7,  32'hFFFF_FFFF};
    vecs[7]  = '{3'd7, 32'd7,          32'd0,          5'd8,  32'd7};
    vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000};
    vecs[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0};
    vecs[10] = '{3'd4, 32'hFFFF_FFF9,  32'd0,          5'd11, 32'hFFFF_FFFF};
    vecs[11] = '{3'd6, 32'hFFFF_FFF9,  32'd0,          5'd12, 32'hFFFF_FFF9};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: x = 32'($urandom_range(0, 100));
        default: ;
      endcase
      r = 5'($urandom_range(0, 31));
      run_op(f, x, y, r, model(f, x, y), $sformatf("rand%0d op%0d", i, f));
    end

    // A start pulse in the middle of a MUL must be ignored
    op = 3'd0; a = 32'd6; b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    op = 3'd5; a = 32'd100; b = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 10;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check("ignored start latency", n, 32'd32);
    check("ignored start result", result, 32'd42);
    check("ignored start rd_out", {27'd0, rd_out}, 32'd3);
    @(posedge clk); #1;
    check("ignored start not queued", {31'd0, busy}, 32'd0);

    // Back-to-back: start held during DONE is accepted with no idle cycle
    op = 3'd0; a = 32'd9; b = 32'd11; rd_in = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check("b2b first result", result, 32'd99);
    op = 3'd7; a = 32'd100; b = 32'd7; rd_in = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b no bubble busy", {31'd0, busy}, 32'd1);
    check("b2b no bubble done", {31'd0, done}, 32'd0);
    check("b2b first result held", result, 32'd99);
    n = 1;
    while (!done && n < 45) begin @(posedge clk); #1; n++; end
    check("b2b done spacing", n, 32'd33);
    check("b2b second result", result, 32'd2);
    check("b2b second rd_out", {27'd0, rd_out}, 32'd5);
    @(posedge clk); #1;

    // Reset at iteration 15 aborts the op without a done pulse
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy",   {31'd0, busy}, 32'd0);
    check("abort done",   {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort rd_out", {27'd0, rd_out}, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    check("abort no done pulse", n, 32'd0);

    // rst wins over start on the same edge
    op = 3'd0; a = 32'd3; b = 32'd5; rd_in = 5'd1; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst over start busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("rst over start idle", {31'd0, busy}, 32'd0);

    run_op(3'd0, 32'd6, 32'd7, 5'd3, 32'd42, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
